// File: rtl/qam_zero_padder_pkg.sv
// ============================================================================
// Module : qam_zero_padder_pkg
// Brief  : Shared QAM-16 transmitter constants: zero-padder defaults and FSM
//          state encodings.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package qam_zero_padder_pkg;

  localparam int c_wid_data  = 4;
  localparam int c_up_factor = 4;
  localparam int c_wid_count = 4;

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_symbol = 2'd1;
  localparam logic [1:0] c_st_zero   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = c_st_idle,
    ST_SYMBOL = c_st_symbol,
    ST_ZERO   = c_st_zero
  } zp_state_t;

endpackage

`default_nettype wire

// File: rtl/qam_zero_padder_if.sv
// ============================================================================
// Module : qam_zero_padder_if
// Brief  : Mapper-side symbol handshake and filter-side upsampled sample bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface qam_zero_padder_if
  import qam_zero_padder_pkg::*;
#(
  parameter int wid_data  = c_wid_data,
  parameter int wid_count = c_wid_count
);

  logic                        ready_mapper;
  logic signed [wid_data-1:0]  data_i;
  logic signed [wid_data-1:0]  data_q;
  logic                        in_ready;
  logic signed [wid_data-1:0]  out_i;
  logic signed [wid_data-1:0]  out_q;
  logic                        ready_zero;
  logic [wid_count-1:0]        phase;

  modport master (
    output ready_mapper, data_i, data_q,
    input  in_ready, out_i, out_q, ready_zero, phase
  );

  modport slave (
    input  ready_mapper, data_i, data_q,
    output in_ready, out_i, out_q, ready_zero, phase
  );

endinterface

`default_nettype wire

// File: rtl/qam_sym_fifo.sv
// ============================================================================
// Module : qam_sym_fifo
// Brief  : Two-entry symbol FIFO; push is qualified by occupancy before any
//          same-cycle pop, so push+pop keeps occupancy and order.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qam_sym_fifo #(
  parameter int wid = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  input  wire logic           push,
  input  wire logic [wid-1:0] push_data,
  input  wire logic           pop,
  output logic      [wid-1:0] pop_data,
  output logic                can_push,
  output logic                not_empty
);

  logic [wid-1:0] r_mem [2];
  logic           r_wr_ptr;
  logic           r_rd_ptr;
  logic [1:0]     r_count;
  logic           w_push;
  logic           w_pop;

  assign can_push  = (r_count < 2'd2);
  assign not_empty = (r_count != 2'd0);
  assign pop_data  = r_mem[r_rd_ptr];
  assign w_push    = push & can_push;
  assign w_pop     = pop & not_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem    <= '{default: '0};
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= push_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/qam_zero_padder.sv
// ============================================================================
// Module : qam_zero_padder
// Brief  : Upsampler for mapper I/Q symbols: each symbol followed by L-1 zero
//          samples, with a 2-deep input FIFO and sticky error flags.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module qam_zero_padder
  import qam_zero_padder_pkg::*;
#(
  parameter int wid_data  = c_wid_data,
  parameter int up_factor = c_up_factor,
  parameter int wid_count = c_wid_count
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic        sel_zero_pad,
  qam_zero_padder_if.slave bus,
  output logic             overflow,
  output logic             underrun
);

  localparam logic [wid_count-1:0] c_last_phase = wid_count'(up_factor - 1);

  zp_state_t                  r_state;
  zp_state_t                  w_state_nxt;
  logic [wid_count-1:0]       r_cnt;
  logic [wid_count-1:0]       w_cnt_nxt;
  logic [2*wid_data-1:0]      r_sym;
  logic [2*wid_data-1:0]      w_sym_nxt;
  logic [2*wid_data-1:0]      w_fifo_data;
  logic                       w_fifo_pop;
  logic                       w_fifo_not_empty;
  logic                       w_fifo_can_push;
  logic                       w_underrun_set;

  logic signed [wid_data-1:0] r_out_i;
  logic signed [wid_data-1:0] r_out_q;
  logic                       r_ready_zero;
  logic [wid_count-1:0]       r_phase;
  logic                       r_overflow;
  logic                       r_underrun;

  qam_sym_fifo #(
    .wid (2*wid_data)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.ready_mapper),
    .push_data ({bus.data_i, bus.data_q}),
    .pop       (w_fifo_pop),
    .pop_data  (w_fifo_data),
    .can_push  (w_fifo_can_push),
    .not_empty (w_fifo_not_empty)
  );

  // Nothing on the output side moves while disabled, so no pop and no underrun.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sym_nxt      = r_sym;
    w_fifo_pop     = 1'b0;
    w_underrun_set = 1'b0;
    if (sel_zero_pad) begin
      case (r_state)
        ST_IDLE: begin
          if (w_fifo_not_empty) begin
            w_fifo_pop  = 1'b1;
            w_sym_nxt   = w_fifo_data;
            w_state_nxt = ST_SYMBOL;
          end
        end
        ST_SYMBOL: begin
          w_cnt_nxt   = wid_count'(1);
          w_state_nxt = ST_ZERO;
        end
        ST_ZERO: begin
          if (r_cnt == c_last_phase) begin
            if (w_fifo_not_empty) begin
              w_fifo_pop  = 1'b1;
              w_sym_nxt   = w_fifo_data;
              w_state_nxt = ST_SYMBOL;
            end else begin
              w_underrun_set = 1'b1;
              w_state_nxt    = ST_IDLE;
            end
          end else begin
            w_cnt_nxt = r_cnt + wid_count'(1);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sym   <= '0;
    end else if (sel_zero_pad) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sym   <= w_sym_nxt;
    end
  end

  // Output registers follow the current state, giving the two-edge latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_i      <= '0;
      r_out_q      <= '0;
      r_ready_zero <= 1'b0;
      r_phase      <= '0;
      r_overflow   <= 1'b0;
      r_underrun   <= 1'b0;
    end else begin
      if (bus.ready_mapper && !w_fifo_can_push) begin
        r_overflow <= 1'b1;
      end
      if (w_underrun_set) begin
        r_underrun <= 1'b1;
      end
      if (sel_zero_pad) begin
        r_ready_zero <= (r_state != ST_IDLE);
        r_out_i      <= (r_state == ST_SYMBOL) ? r_sym[2*wid_data-1 -: wid_data] : '0;
        r_out_q      <= (r_state == ST_SYMBOL) ? r_sym[wid_data-1:0] : '0;
        r_phase      <= (r_state == ST_ZERO) ? r_cnt : '0;
      end
    end
  end

  assign bus.in_ready   = w_fifo_can_push;
  assign bus.out_i      = r_out_i;
  assign bus.out_q      = r_out_q;
  assign bus.ready_zero = r_ready_zero;
  assign bus.phase      = r_phase;
  assign overflow       = r_overflow;
  assign underrun       = r_underrun;

endmodule

`default_nettype wire

// File: tb/tb_qam_zero_padder.sv
// ============================================================================
// Module : tb_qam_zero_padder
// Brief  : Self-checking bench for qam_zero_padder at L = 4, 2 and 16.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_qam_zero_padder;
  import qam_zero_padder_pkg::*;

  localparam int c_w  = 4;
  localparam int c_wc = 4;

  typedef logic signed [c_w-1:0] samp_t;
  typedef struct {logic rz; samp_t i; samp_t q; int ph;} out_t;
  typedef struct {
    logic rm; int di; int dq; logic sel;
    logic rz; int oi; int oq; int ph; logic und; logic ir;
  } vec_t;

  logic  clk = 1'b0;
  logic  rst_n;
  logic  rm;
  logic  sel;
  samp_t di;
  samp_t dq;
  logic  ovf4, und4, ovf2, und2, ovf16, und16;
  int    cur;
  int    L;
  int    n_vec;
  int    n_err;

  always #5 clk = ~clk;

  qam_zero_padder_if #(.wid_data(c_w), .wid_count(c_wc)) bus4 ();
  qam_zero_padder_if #(.wid_data(c_w), .wid_count(c_wc)) bus2 ();
  qam_zero_padder_if #(.wid_data(c_w), .wid_count(c_wc)) bus16 ();

  assign bus4.ready_mapper  = rm;  assign bus4.data_i  = di; assign bus4.data_q  = dq;
  assign bus2.ready_mapper  = rm;  assign bus2.data_i  = di; assign bus2.data_q  = dq;
  assign bus16.ready_mapper = rm;  assign bus16.data_i = di; assign bus16.data_q = dq;

  qam_zero_padder #(.wid_data(c_w), .up_factor(4), .wid_count(c_wc)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .sel_zero_pad(sel), .bus(bus4), .overflow(ovf4), .underrun(und4));
  qam_zero_padder #(.wid_data(c_w), .up_factor(2), .wid_count(c_wc)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .sel_zero_pad(sel), .bus(bus2), .overflow(ovf2), .underrun(und2));
  qam_zero_padder #(.wid_data(c_w), .up_factor(16), .wid_count(c_wc)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .sel_zero_pad(sel), .bus(bus16), .overflow(ovf16), .underrun(und16));

  logic            o_rz, o_ir, o_ovf, o_und;
  samp_t           o_i, o_q;
  logic [c_wc-1:0] o_ph;

  always_comb begin
    o_rz = bus4.ready_zero; o_ir = bus4.in_ready; o_i = bus4.out_i; o_q = bus4.out_q;
    o_ph = bus4.phase; o_ovf = ovf4; o_und = und4;
    if (cur == 1) begin
      o_rz = bus2.ready_zero; o_ir = bus2.in_ready; o_i = bus2.out_i; o_q = bus2.out_q;
      o_ph = bus2.phase; o_ovf = ovf2; o_und = und2;
    end else if (cur == 2) begin
      o_rz = bus16.ready_zero; o_ir = bus16.in_ready; o_i = bus16.out_i; o_q = bus16.out_q;
      o_ph = bus16.phase; o_ovf = ovf16; o_und = und16;
    end
  end

  // Reference model: a symbol queue plus a queue of scheduled output samples.
  // Whenever the schedule drains on an enabled edge, the next queued symbol's
  // whole L-sample frame is scheduled; draining with nothing queued is underrun.
  logic [2*c_w-1:0] m_fifo [$];
  out_t             m_frame [$];
  out_t             m_vis;
  logic             m_ovf, m_und, m_ir;

  function automatic out_t mk(logic rz, samp_t i, samp_t q, int ph);
    out_t r;
    r.rz = rz; r.i = i; r.q = q; r.ph = ph;
    return r;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_frame.delete();
    m_vis = mk(1'b0, '0, '0, 0);
    m_ovf = 1'b0;
    m_und = 1'b0;
    m_ir  = 1'b1;
  endtask

  task automatic model_step();
    int          pre_occ;
    bit          had;
    logic [2*c_w-1:0] s;
    samp_t       si, sq;
    pre_occ = m_fifo.size();
    if (sel) begin
      had = (m_frame.size() != 0);
      if (had) m_vis = m_frame.pop_front();
      else     m_vis = mk(1'b0, '0, '0, 0);
      if (m_frame.size() == 0) begin
        if (pre_occ > 0) begin
          s  = m_fifo.pop_front();
          si = s[2*c_w-1:c_w];
          sq = s[c_w-1:0];
          m_frame.push_back(mk(1'b1, si, sq, 0));
          for (int k = 1; k < L; k++) m_frame.push_back(mk(1'b1, '0, '0, k));
        end else if (had) begin
          m_und = 1'b1;
        end
      end
    end
    if (rm) begin
      if (pre_occ < 2) m_fifo.push_back({di, dq});
      else             m_ovf = 1'b1;
    end
    m_ir = (m_fifo.size() < 2);
  endtask

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (L=%0d, t=%0t)", name, act, exp, L, $time);
    end
  endtask

  task automatic model_check();
    chk("ready_zero", int'(o_rz), int'(m_vis.rz));
    chk("out_i", int'(o_i), int'(m_vis.i));
    chk("out_q", int'(o_q), int'(m_vis.q));
    chk("phase", int'(o_ph), m_vis.ph);
    chk("in_ready", int'(o_ir), int'(m_ir));
    chk("overflow", int'(o_ovf), int'(m_ovf));
    chk("underrun", int'(o_und), int'(m_und));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    #1;
    model_check();
  endtask

  task automatic do_reset();
    rm = 1'b0; sel = 1'b0; rst_n = 1'b0;
    model_reset();
    #1;
    model_check();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic random_run(int cycles, int push_pct);
    for (int c = 0; c < cycles; c++) begin
      rm  = ($urandom_range(0, 99) < push_pct);
      di  = samp_t'($urandom);
      dq  = samp_t'($urandom);
      sel = ($urandom_range(0, 9) != 0);
      tick();
    end
    rm = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [7];
    int   n_rz, found, nsym, last, maxph, sent;
    int   got_i [$];

    n_vec = 0; n_err = 0; cur = 0; L = 4;
    rm = 1'b0; sel = 1'b0; di = '0; dq = '0; rst_n = 1'b1;

    //          rm  di  dq  sel  rz oi  oq  ph und ir
    tbl[0] = '{1'b1, 3, -5, 1'b1, 1'b0, 0,  0, 0, 1'b0, 1'b1};
    tbl[1] = '{1'b0, 0,  0, 1'b1, 1'b0, 0,  0, 0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 0,  0, 1'b1, 1'b1, 3, -5, 0, 1'b0, 1'b1};
    tbl[3] = '{1'b0, 0,  0, 1'b1, 1'b1, 0,  0, 1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 0,  0, 1'b1, 1'b1, 0,  0, 2, 1'b0, 1'b1};
    tbl[5] = '{1'b0, 0,  0, 1'b1, 1'b1, 0,  0, 3, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 0,  0, 1'b1, 1'b0, 0,  0, 0, 1'b1, 1'b1};

    do_reset();

    // Single symbol through to underrun
    for (int k = 0; k < 7; k++) begin
      rm = tbl[k].rm; di = samp_t'(tbl[k].di); dq = samp_t'(tbl[k].dq); sel = tbl[k].sel;
      tick();
      chk("tbl_ready_zero", int'(o_rz), int'(tbl[k].rz));
      chk("tbl_out_i", int'(o_i), tbl[k].oi);
      chk("tbl_out_q", int'(o_q), tbl[k].oq);
      chk("tbl_phase", int'(o_ph), tbl[k].ph);
      chk("tbl_underrun", int'(o_und), int'(tbl[k].und));
      chk("tbl_in_ready", int'(o_ir), int'(tbl[k].ir));
    end

    // Continuous stream: one push every 4 cycles, 8 symbols
    do_reset();
    sel = 1'b1; n_rz = 0;
    for (int c = 0; c < 34; c++) begin
      rm = ((c % 4) == 0) && (c < 32);
      di = samp_t'((c / 4) - 4);
      dq = samp_t'(3 - (c / 4));
      tick();
      if (c >= 2) begin
        if (o_rz) n_rz++;
        chk("stream_phase", int'(o_ph), (c - 2) % 4);
      end
      if (c == 32) chk("stream_underrun", int'(o_und), 0);
    end
    rm = 1'b0;
    chk("stream_rz_count", n_rz, 32);

    // Overflow while frozen: third of three back-to-back pushes is dropped
    do_reset();
    for (int c = 0; c < 3; c++) begin
      rm = 1'b1; di = samp_t'(c + 1); dq = samp_t'(-(c + 1));
      tick();
      if (c == 1) chk("ovf_in_ready_full", int'(o_ir), 0);
      chk("ovf_flag", int'(o_ovf), (c == 2) ? 1 : 0);
    end
    rm = 1'b0; sel = 1'b1;
    got_i.delete();
    for (int c = 0; c < 12; c++) begin
      tick();
      if (o_rz && o_ph == 0) got_i.push_back(int'(o_i));
    end
    chk("ovf_kept_count", got_i.size(), 2);
    if (got_i.size() == 2) begin
      chk("ovf_first_kept", got_i[0], 1);
      chk("ovf_second_kept", got_i[1], 2);
    end

    // Freeze at phase 2 for 5 cycles, with a push during the freeze
    do_reset();
    sel = 1'b1; rm = 1'b1; di = 5; dq = -2;
    tick();
    rm = 1'b0; found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      tick();
      if (o_rz && o_ph == 2) found = 1;
    end
    chk("frz_reach_phase2", found, 1);
    sel = 1'b0; rm = 1'b1; di = -3; dq = 6;
    for (int c = 0; c < 5; c++) begin
      tick();
      rm = 1'b0;
      chk("frz_phase_held", int'(o_ph), 2);
      chk("frz_rz_held", int'(o_rz), 1);
      chk("frz_no_underrun", int'(o_und), 0);
    end
    sel = 1'b1;
    tick();
    chk("frz_resume_phase", int'(o_ph), 3);
    tick();
    chk("frz_next_sym_i", int'(o_i), -3);
    chk("frz_next_sym_q", int'(o_q), 6);
    chk("frz_next_phase", int'(o_ph), 0);

    // Asynchronous reset during ZERO with two symbols buffered
    do_reset();
    sel = 1'b1; rm = 1'b1; di = 2; dq = 2;
    tick();
    rm = 1'b0;
    tick(); tick();
    rm = 1'b1; di = 1; tick();
    di = 4; tick();
    rm = 1'b0;
    chk("rst_pre_full", int'(o_ir), 0);
    chk("rst_pre_in_zero", int'(o_ph), 2);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_rz_now", int'(o_rz), 0);
    chk("rst_phase_now", int'(o_ph), 0);
    chk("rst_in_ready_now", int'(o_ir), 1);
    model_check();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("rst_fifo_empty", int'(o_rz), 0);
    end

    // Randomised traffic against the model at L = 4
    do_reset();
    random_run(400, 30);
    random_run(400, 70);

    // Parameter sweep: L = 2 and L = 16
    for (int s = 1; s <= 2; s++) begin
      cur = s;
      L   = (s == 1) ? 2 : 16;
      do_reset();
      sel = 1'b1; sent = 0; nsym = 0; last = -1; maxph = 0;
      for (int c = 0; c < 8 * L + 10; c++) begin
        rm = o_ir && (sent < 6);
        di = samp_t'(sent + 1); dq = samp_t'(-(sent + 1));
        if (rm) sent++;
        tick();
        if (o_rz && o_ph == 0) begin
          if (last >= 0) chk("sweep_spacing", c - last, L);
          last = c;
          nsym++;
        end
        if (o_rz && int'(o_ph) > maxph) maxph = int'(o_ph);
      end
      rm = 1'b0;
      chk("sweep_symbols", nsym, 6);
      chk("sweep_peak_phase", maxph, L - 1);
      do_reset();
      random_run(300, 50);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
